// File: rtl/mips_pkg.sv
// Store-path encodings shared by the MEM-stage write-side blocks.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_SB  = 2'b00,
        ST_SH  = 2'b01,
        ST_SW  = 2'b10,
        ST_RSV = 2'b11
    } st_op_e;

    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_LO_HALF = 4'b0011;
    localparam logic [3:0] BE_HI_HALF = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

endpackage

// File: rtl/store_buffer_if.sv
// Store-buffer bus: MEM-stage store port, memory write port, load probe.
interface store_buffer_if #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              st_valid;
    logic              st_ready;
    logic [1:0]        st_op;
    logic [ADDR_W-1:0] st_addr;
    logic [31:0]       st_data;
    logic              st_misalign;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic              mem_ack;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_hit;
    logic              empty;
    logic [CW-1:0]     count;

    modport master (
        output st_valid, st_op, st_addr, st_data,
        output mem_ack, ld_addr,
        input  st_ready, st_misalign, mem_req, mem_addr,
        input  mem_wdata, mem_be, ld_hit, empty, count
    );

    modport slave (
        input  st_valid, st_op, st_addr, st_data,
        input  mem_ack, ld_addr,
        output st_ready, st_misalign, mem_req, mem_addr,
        output mem_wdata, mem_be, ld_hit, empty, count
    );

endinterface

// File: rtl/store_lane_fmt.sv
// Narrows a register value into lane-replicated write data and byte enables.
module store_lane_fmt
    import mips_pkg::*;
(
    input  st_op_e      op,
    input  logic [1:0]  lane,
    input  logic [31:0] data,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic        misalign
);

    always_comb begin
        wdata    = data;
        be       = 4'b0000;
        misalign = 1'b0;
        unique case (op)
            ST_SB: begin
                wdata = {4{data[7:0]}};
                be    = BE_BYTE0 << lane;
            end
            ST_SH: begin
                wdata    = {2{data[15:0]}};
                be       = lane[1] ? BE_HI_HALF : BE_LO_HALF;
                misalign = lane[0];
            end
            ST_SW: begin
                be       = BE_WORD;
                misalign = |lane;
            end
            ST_RSV: begin
                misalign = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// Committed-store FIFO draining to data memory with word-granular load probe.
module store_buffer
    import mips_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input logic           clk,
    input logic           rst,
    store_buffer_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_W-1:0] WMASK = ~ADDR_W'(3);

    logic [ADDR_W-1:0] q_addr  [DEPTH];
    logic [31:0]       q_wdata [DEPTH];
    logic [3:0]        q_be    [DEPTH];
    logic [DEPTH-1:0]  q_vld;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     cnt;
    logic              mis_q;

    logic [31:0] f_wdata;
    logic [3:0]  f_be;
    logic        f_mis;
    logic        full;
    logic        empty;
    logic        accept;
    logic        push;
    logic        pop;

    store_lane_fmt u_fmt (
        .op       (st_op_e'(bus.st_op)),
        .lane     (bus.st_addr[1:0]),
        .data     (bus.st_data),
        .wdata    (f_wdata),
        .be       (f_be),
        .misalign (f_mis)
    );

    assign empty  = (cnt == '0);
    assign full   = (cnt == CW'(DEPTH));
    assign accept = bus.st_valid && !full;
    assign push   = accept && !f_mis;
    assign pop    = !empty && bus.mem_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_addr[i]  <= '0;
                q_wdata[i] <= '0;
                q_be[i]    <= '0;
            end
            q_vld  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            mis_q  <= 1'b0;
        end else begin
            mis_q <= accept && f_mis;
            // push never targets the popped slot: it requires !full, pop requires !empty
            if (push) begin
                q_addr[wr_ptr]  <= bus.st_addr & WMASK;
                q_wdata[wr_ptr] <= f_wdata;
                q_be[wr_ptr]    <= f_be;
                q_vld[wr_ptr]   <= 1'b1;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                q_vld[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
            if (push && !pop)
                cnt <= cnt + 1'b1;
            else if (pop && !push)
                cnt <= cnt - 1'b1;
        end
    end

    always_comb begin
        bus.ld_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (q_vld[i] && (q_addr[i] == (bus.ld_addr & WMASK)))
                bus.ld_hit = 1'b1;
    end

    assign bus.st_ready    = !full;
    assign bus.st_misalign = mis_q;
    assign bus.mem_req     = !empty;
    assign bus.mem_addr    = empty ? '0 : q_addr[rd_ptr];
    assign bus.mem_wdata   = empty ? '0 : q_wdata[rd_ptr];
    assign bus.mem_be      = empty ? '0 : q_be[rd_ptr];
    assign bus.empty       = empty;
    assign bus.count       = cnt;

endmodule

// File: tb/tb_store_buffer.sv
// Scenario bench for store_buffer with a drain-order scoreboard.
module tb_store_buffer;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;

    logic [31:0] sb_a[$];
    logic [31:0] sb_d[$];
    logic [3:0]  sb_b[$];

    store_buffer_if #(.ADDR_W(32), .DEPTH(4)) sbif ();

    store_buffer #(.DEPTH(4), .ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sbif)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void model(input logic [1:0] op, input logic [31:0] a,
                                  input logic [31:0] d, output logic [31:0] wd,
                                  output logic [3:0] be, output logic ok);
        ok = 1'b1;
        wd = d;
        be = 4'b0000;
        case (op)
            2'b00: begin
                wd = {d[7:0], d[7:0], d[7:0], d[7:0]};
                case (a[1:0])
                    2'd0: be = 4'b0001;
                    2'd1: be = 4'b0010;
                    2'd2: be = 4'b0100;
                    default: be = 4'b1000;
                endcase
            end
            2'b01: begin
                wd = {d[15:0], d[15:0]};
                be = a[1] ? 4'b1100 : 4'b0011;
                ok = (a[0] == 1'b0);
            end
            2'b10: begin
                be = 4'b1111;
                ok = (a[1:0] == 2'b00);
            end
            default: ok = 1'b0;
        endcase
    endfunction

    task automatic sb_push(input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] d);
        logic [31:0] wd;
        logic [3:0] be;
        logic ok;
        model(op, a, d, wd, be, ok);
        if (ok) begin
            sb_a.push_back({a[31:2], 2'b00});
            sb_d.push_back(wd);
            sb_b.push_back(be);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] d);
        sbif.st_valid = 1'b1;
        sbif.st_op = op;
        sbif.st_addr = a;
        sbif.st_data = d;
        @(negedge clk);
        total++;
        if (sbif.st_ready !== 1'b1) begin
            bad++;
            $display("FAIL send_ready addr=%h got=%b want=1", a, sbif.st_ready);
        end else begin
            sb_push(op, a, d);
        end
        step();
        sbif.st_valid = 1'b0;
    endtask

    task automatic drain();
        sbif.mem_ack = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (sbif.empty === 1'b1) break;
        end
        sbif.mem_ack = 1'b0;
        total++;
        if (sbif.empty !== 1'b1) begin
            bad++;
            $display("FAIL drain_timeout count=%0d want=0", sbif.count);
        end
        total++;
        if (sb_a.size() != 0) begin
            bad++;
            $display("FAIL drain_left got=%0d entries want=0", sb_a.size());
        end
    endtask

    // Every accepted pop is checked against the oldest expected store.
    always @(negedge clk) begin
        if (!rst && sbif.mem_req && sbif.mem_ack) begin
            total++;
            if (sb_a.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected addr=%h", sbif.mem_addr);
            end else begin
                if (sbif.mem_addr !== sb_a[0] || sbif.mem_wdata !== sb_d[0] ||
                    sbif.mem_be !== sb_b[0]) begin
                    bad++;
                    $display("FAIL pop_head got=%h/%h/%b want=%h/%h/%b",
                             sbif.mem_addr, sbif.mem_wdata, sbif.mem_be,
                             sb_a[0], sb_d[0], sb_b[0]);
                end
                void'(sb_a.pop_front());
                void'(sb_d.pop_front());
                void'(sb_b.pop_front());
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        sbif.st_valid = 1'b0;
        sbif.st_op = 2'b00;
        sbif.st_addr = '0;
        sbif.st_data = '0;
        sbif.mem_ack = 1'b0;
        sbif.ld_addr = '0;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (sbif.st_ready !== 1'b1 || sbif.mem_req !== 1'b0 ||
            sbif.empty !== 1'b1 || sbif.count !== 3'd0) begin
            bad++;
            $display("FAIL reset_ctl got rdy=%b req=%b empty=%b cnt=%0d want 1 0 1 0",
                     sbif.st_ready, sbif.mem_req, sbif.empty, sbif.count);
        end
        total++;
        if (sbif.mem_addr !== 32'h0 || sbif.mem_wdata !== 32'h0 ||
            sbif.mem_be !== 4'h0 || sbif.st_misalign !== 1'b0 ||
            sbif.ld_hit !== 1'b0) begin
            bad++;
            $display("FAIL reset_data got %h %h %b mis=%b hit=%b want zeros",
                     sbif.mem_addr, sbif.mem_wdata, sbif.mem_be,
                     sbif.st_misalign, sbif.ld_hit);
        end
        step();
    endtask

    task automatic test_sb();
        send(2'b00, 32'h1003, 32'hAB);
        @(negedge clk);
        total++;
        if (sbif.mem_req !== 1'b1 || sbif.mem_addr !== 32'h1000 ||
            sbif.mem_wdata !== 32'hABABABAB || sbif.mem_be !== 4'b1000 ||
            sbif.count !== 3'd1) begin
            bad++;
            $display("FAIL sb_head got req=%b %h %h %b cnt=%0d want 1 1000 ABABABAB 1000 1",
                     sbif.mem_req, sbif.mem_addr, sbif.mem_wdata,
                     sbif.mem_be, sbif.count);
        end
        step();
        drain();
    endtask

    task automatic test_misalign();
        send(2'b01, 32'h2002, 32'h1234BEEF);
        @(negedge clk);
        total++;
        if (sbif.mem_wdata !== 32'hBEEFBEEF || sbif.mem_be !== 4'b1100 ||
            sbif.count !== 3'd1) begin
            bad++;
            $display("FAIL sh_head got %h %b cnt=%0d want BEEFBEEF 1100 1",
                     sbif.mem_wdata, sbif.mem_be, sbif.count);
        end
        step();
        send(2'b01, 32'h2001, 32'h5555);
        @(negedge clk);
        total++;
        if (sbif.st_misalign !== 1'b1 || sbif.count !== 3'd1) begin
            bad++;
            $display("FAIL sh_misalign got mis=%b cnt=%0d want 1 1",
                     sbif.st_misalign, sbif.count);
        end
        step();
        @(negedge clk);
        total++;
        if (sbif.st_misalign !== 1'b0) begin
            bad++;
            $display("FAIL misalign_pulse got=%b want=0", sbif.st_misalign);
        end
        step();
        send(2'b11, 32'h3000, 32'h7777);
        @(negedge clk);
        total++;
        if (sbif.st_misalign !== 1'b1 || sbif.count !== 3'd1) begin
            bad++;
            $display("FAIL rsv_op got mis=%b cnt=%0d want 1 1",
                     sbif.st_misalign, sbif.count);
        end
        step();
        drain();
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++)
            send(2'b10, 32'h10 + 32'(4 * i), 32'hA0 + 32'(i));
        @(negedge clk);
        total++;
        if (sbif.st_ready !== 1'b0 || sbif.count !== 3'd4) begin
            bad++;
            $display("FAIL full got rdy=%b cnt=%0d want 0 4",
                     sbif.st_ready, sbif.count);
        end
        step();
        sbif.st_valid = 1'b1;
        sbif.st_op = 2'b10;
        sbif.st_addr = 32'h20;
        sbif.st_data = 32'h55;
        sbif.mem_ack = 1'b1;
        @(negedge clk);
        total++;
        if (sbif.st_ready !== 1'b0) begin
            bad++;
            $display("FAIL full_pop_same got rdy=%b want 0", sbif.st_ready);
        end
        step();
        sbif.mem_ack = 1'b0;
        @(negedge clk);
        total++;
        if (sbif.st_ready !== 1'b1) begin
            bad++;
            $display("FAIL full_room got rdy=%b want 1", sbif.st_ready);
        end else begin
            sb_push(2'b10, 32'h20, 32'h55);
        end
        step();
        sbif.st_valid = 1'b0;
        @(negedge clk);
        total++;
        if (sbif.count !== 3'd4) begin
            bad++;
            $display("FAIL full_refill got cnt=%0d want 4", sbif.count);
        end
        step();
        drain();
    endtask

    task automatic test_ld_hit();
        sbif.ld_addr = 32'h43;
        sbif.st_valid = 1'b1;
        sbif.st_op = 2'b10;
        sbif.st_addr = 32'h40;
        sbif.st_data = 32'hDEAD;
        @(negedge clk);
        total++;
        if (sbif.ld_hit !== 1'b0) begin
            bad++;
            $display("FAIL ld_enq_excl got=%b want=0", sbif.ld_hit);
        end
        sb_push(2'b10, 32'h40, 32'hDEAD);
        step();
        sbif.st_valid = 1'b0;
        @(negedge clk);
        total++;
        if (sbif.ld_hit !== 1'b1) begin
            bad++;
            $display("FAIL ld_hit_43 got=%b want=1", sbif.ld_hit);
        end
        step();
        sbif.ld_addr = 32'h44;
        @(negedge clk);
        total++;
        if (sbif.ld_hit !== 1'b0) begin
            bad++;
            $display("FAIL ld_hit_44 got=%b want=0", sbif.ld_hit);
        end
        step();
        sbif.ld_addr = 32'h43;
        sbif.mem_ack = 1'b1;
        @(negedge clk);
        total++;
        if (sbif.ld_hit !== 1'b1) begin
            bad++;
            $display("FAIL ld_hit_acking got=%b want=1", sbif.ld_hit);
        end
        step();
        sbif.mem_ack = 1'b0;
        @(negedge clk);
        total++;
        if (sbif.ld_hit !== 1'b0 || sbif.empty !== 1'b1) begin
            bad++;
            $display("FAIL ld_hit_after got hit=%b empty=%b want 0 1",
                     sbif.ld_hit, sbif.empty);
        end
        step();
    endtask

    task automatic test_back_to_back();
        send(2'b10, 32'h100, 32'h11110000);
        send(2'b10, 32'h104, 32'h22220000);
        sbif.st_valid = 1'b1;
        sbif.st_op = 2'b00;
        sbif.st_addr = 32'h109;
        sbif.st_data = 32'hC3;
        sbif.mem_ack = 1'b1;
        @(negedge clk);
        total++;
        if (sbif.st_ready !== 1'b1 || sbif.count !== 3'd2) begin
            bad++;
            $display("FAIL b2b_pre got rdy=%b cnt=%0d want 1 2",
                     sbif.st_ready, sbif.count);
        end else begin
            sb_push(2'b00, 32'h109, 32'hC3);
        end
        step();
        sbif.st_valid = 1'b0;
        sbif.mem_ack = 1'b0;
        @(negedge clk);
        total++;
        if (sbif.count !== 3'd2) begin
            bad++;
            $display("FAIL b2b_count got=%0d want 2", sbif.count);
        end
        step();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (sbif.mem_req !== 1'b1 || sbif.mem_addr !== 32'h104 ||
                sbif.mem_wdata !== sb_d[0] || sbif.mem_be !== 4'b1111) begin
                bad++;
                $display("FAIL hold_%0d got req=%b %h %h %b want 1 104 %h 1111",
                         k, sbif.mem_req, sbif.mem_addr, sbif.mem_wdata,
                         sbif.mem_be, sb_d[0]);
            end
            step();
        end
        drain();
    endtask

    task automatic test_async_reset();
        send(2'b10, 32'h200, 32'h1);
        send(2'b10, 32'h204, 32'h2);
        send(2'b10, 32'h208, 32'h3);
        @(negedge clk);
        total++;
        if (sbif.mem_req !== 1'b1 || sbif.count !== 3'd3) begin
            bad++;
            $display("FAIL areset_pre got req=%b cnt=%0d want 1 3",
                     sbif.mem_req, sbif.count);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (sbif.mem_req !== 1'b0 || sbif.count !== 3'd0 ||
            sbif.empty !== 1'b1 || sbif.st_ready !== 1'b1) begin
            bad++;
            $display("FAIL areset got req=%b cnt=%0d empty=%b rdy=%b want 0 0 1 1",
                     sbif.mem_req, sbif.count, sbif.empty, sbif.st_ready);
        end
        sb_a.delete();
        sb_d.delete();
        sb_b.delete();
        step();
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (sbif.empty !== 1'b1 || sbif.mem_be !== 4'h0) begin
            bad++;
            $display("FAIL areset_after got empty=%b be=%b want 1 0000",
                     sbif.empty, sbif.mem_be);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_sb();
        test_misalign();
        test_full();
        test_ld_hit();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
